// File: rtl/pie_cmd_serializer_if.sv
// Command/encoder bundle for pie_cmd_serializer.
// master: command source plus encoder-side request strobe (upstream and encoder shell).
// slave : the serializer itself.
interface pie_cmd_serializer_if #(
   parameter int MAX_BITS = 128,
   parameter int LEN_W    = $clog2(MAX_BITS + 1)
);
   logic [MAX_BITS-1:0] cmd_data;
   logic [LEN_W-1:0]    cmd_len;
   logic                cmd_preamble;
   logic                cmd_crc16;
   logic                cmd_valid;
   logic                cmd_ready;
   logic                enc_bit_req;
   logic                enc_bit;
   logic                enc_preamble;
   logic                enc_rst;
   logic                busy;
   logic                done;

   modport master (
      output cmd_data, cmd_len, cmd_preamble, cmd_crc16, cmd_valid, enc_bit_req,
      input  cmd_ready, enc_bit, enc_preamble, enc_rst, busy, done
   );

   modport slave (
      input  cmd_data, cmd_len, cmd_preamble, cmd_crc16, cmd_valid, enc_bit_req,
      output cmd_ready, enc_bit, enc_preamble, enc_rst, busy, done
   );
endinterface

// File: rtl/pie_cmd_serializer.sv
// pie_cmd_serializer: feeds one reader command word per frame to the PIE encoder.
// The encoder is held in reset between frames, released on accept so it emits its
// preamble, then served one bit per enc_bit_req; reset is re-asserted after the final
// symbol and held for MIN_GAP cycles before the next command is accepted.
// Optional feature macro: CMD_CRC_EN appends the ones-complement CRC-16/EPC
// (poly 0x1021, preset 0xFFFF) MSB first when cmd_crc16 was set at accept.
module pie_cmd_serializer #(
   parameter int MAX_BITS = 128,
   parameter int LEN_W    = $clog2(MAX_BITS + 1),
   parameter int MIN_GAP  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pie_cmd_serializer_if.slave  bus
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SEND = 3'd1;
`ifdef CMD_CRC_EN
   localparam logic [2:0] ST_CRC  = 3'd2;
`endif
   localparam logic [2:0] ST_TAIL = 3'd3;
   localparam logic [2:0] ST_GAP  = 3'd4;

   localparam int               GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);
   localparam logic [GAP_W-1:0] GAP_END = GAP_W'(MIN_GAP - 1);

   // Saturate an oversize length to the shift register capacity.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

   logic [2:0]          state;
   logic [LEN_W-1:0]    bit_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic                enc_bit_r;
   logic                enc_rst_r;
   logic                pre_r;
   logic                busy_r;
   logic                done_r;
   logic [MAX_BITS-1:0] sreg;

   logic [LEN_W-1:0]    len_c;
   logic [MAX_BITS-1:0] sreg_load;
   logic                accept;
   logic                req;

   // Left-align the command so the first bit to send sits in the MSB.
   assign len_c     = clamp_len(bus.cmd_len);
   assign sreg_load = bus.cmd_data << (MAX_LEN - len_c);
   assign accept    = bus.cmd_valid && (state == ST_IDLE);
   assign req       = bus.enc_bit_req;

   assign bus.cmd_ready    = (state == ST_IDLE);
   assign bus.enc_bit      = enc_bit_r;
   assign bus.enc_rst      = enc_rst_r;
   assign bus.enc_preamble = pre_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;

`ifdef CMD_CRC_EN
   // One serial CRC-16 step over a single data bit, MSB-first.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      return {crc[14:0], 1'b0} ^ (((crc[15] ^ b) != 1'b0) ? 16'h1021 : 16'h0000);
   endfunction

   logic [15:0] crc_r;
   logic [15:0] crc_next;
   logic [4:0]  crc_cnt;
   logic        crc_sel;

   // The bit currently on enc_bit is always sreg's MSB while sending data.
   assign crc_next = crc16_step(crc_r, sreg[MAX_BITS-1]);

   // CRC register: preset on accept, update per data bit, then shift out.
   always_ff @(posedge clk) begin
      if (accept) begin
         crc_r <= 16'hFFFF;
      end else if (state == ST_SEND && req) begin
         crc_r <= crc_next;
      end else if (state == ST_CRC && req) begin
         crc_r <= crc_r << 1;
      end
   end
`else
   logic unused_crc;
   assign unused_crc = ^{bus.cmd_crc16, sreg[MAX_BITS-1]};
`endif

   // Command shift register: load on accept, advance one bit per data request.
   always_ff @(posedge clk) begin
      if (accept) begin
         sreg <= sreg_load;
      end else if (state == ST_SEND && req) begin
         sreg <= sreg << 1;
      end
   end

   // Frame sequencer and registered encoder-facing outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         enc_bit_r <= 1'b0;
         enc_rst_r <= 1'b1;
         pre_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
`ifdef CMD_CRC_EN
         crc_cnt   <= '0;
         crc_sel   <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (len_c == '0) begin
                     done_r <= 1'b1;
                  end else begin
                     state     <= ST_SEND;
                     bit_cnt   <= len_c;
                     enc_bit_r <= sreg_load[MAX_BITS-1];
                     enc_rst_r <= 1'b0;
                     pre_r     <= bus.cmd_preamble;
                     busy_r    <= 1'b1;
`ifdef CMD_CRC_EN
                     crc_sel   <= bus.cmd_crc16;
`endif
                  end
               end
            end
            ST_SEND: begin
               if (req) begin
                  if (bit_cnt == LEN_W'(1)) begin
                     state     <= ST_TAIL;
                     enc_bit_r <= 1'b0;
`ifdef CMD_CRC_EN
                     if (crc_sel) begin
                        state     <= ST_CRC;
                        crc_cnt   <= 5'd16;
                        enc_bit_r <= ~crc_next[15];
                     end
`endif
                  end else begin
                     bit_cnt   <= bit_cnt - LEN_W'(1);
                     enc_bit_r <= sreg[MAX_BITS-2];
                  end
               end
            end
`ifdef CMD_CRC_EN
            ST_CRC: begin
               if (req) begin
                  if (crc_cnt == 5'd1) begin
                     state     <= ST_TAIL;
                     enc_bit_r <= 1'b0;
                  end else begin
                     crc_cnt   <= crc_cnt - 5'd1;
                     enc_bit_r <= ~crc_r[14];
                  end
               end
            end
`endif
            ST_TAIL: begin
               // This request marks the end of the final symbol.
               if (req) begin
                  state     <= ST_GAP;
                  enc_rst_r <= 1'b1;
                  done_r    <= 1'b1;
                  busy_r    <= 1'b0;
                  gap_cnt   <= '0;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_END) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pie_cmd_serializer.sv
// Testbench for pie_cmd_serializer: table of frames, hand-written corner sequences
// (busy/gap acceptance, zero length, mid-frame reset), then random frames checked
// against a bit-list reference model built from the command word.
module tb_pie_cmd_serializer;
   localparam int MAX_BITS = 128;
   localparam int LEN_W    = $clog2(MAX_BITS + 1);
   localparam int MIN_GAP  = 16;
`ifdef CMD_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pie_cmd_serializer_if #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) bus ();

   pie_cmd_serializer #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W), .MIN_GAP(MIN_GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [MAX_BITS-1:0] data;
      int                  len;
      bit                  pre;
      bit                  crc;
      int                  nbits;
   } vec_t;

   int checks = 0;
   int errors = 0;
   bit exp_q[$];
   bit got_q[$];
   int rdy_bad;
   int pre_bad;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the bit sequence the encoder must receive for a command.
   function automatic void build_exp(input logic [MAX_BITS-1:0] d, input int len, input bit crc);
      int n;
      logic [15:0] r;
      n = (len > MAX_BITS) ? MAX_BITS : len;
      r = 16'hFFFF;
      exp_q.delete();
      for (int i = n - 1; i >= 0; i--) begin
         exp_q.push_back(d[i]);
         r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      end
      if (crc && CRC_ON) begin
         for (int i = 15; i >= 0; i--) exp_q.push_back(~r[i]);
      end
   endfunction

   task automatic send_cmd(input logic [MAX_BITS-1:0] d, input int len, input bit pre, input bit crc);
      int t;
      t = 0;
      while (!bus.cmd_ready && t < 200) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 200) chk("ready_timeout", 0, 1);
      bus.cmd_data     = d;
      bus.cmd_len      = LEN_W'(len);
      bus.cmd_preamble = pre;
      bus.cmd_crc16    = crc;
      bus.cmd_valid    = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid    = 1'b0;
   endtask

   // Issue bit requests with random spacing, capturing enc_bit in each request cycle.
   task automatic serve(input int max_req, output bit ended);
      int  n;
      bit  b;
      logic pre0;
      n = 0;
      ended = 1'b0;
      pre0 = bus.enc_preamble;
      got_q.delete();
      for (int g = 0; g < 2000 && n < max_req; g++) begin
         bus.enc_bit_req = 1'b1;
         b = bus.enc_bit;
         @(posedge clk); #1;
         bus.enc_bit_req = 1'b0;
         n++;
         if (bus.cmd_ready) rdy_bad++;
         if (bus.enc_preamble !== pre0) pre_bad++;
         if (bus.enc_rst) begin
            ended = 1'b1;
            break;
         end
         got_q.push_back(b);
         repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
            if (bus.cmd_ready) rdy_bad++;
            if (bus.enc_preamble !== pre0) pre_bad++;
         end
      end
   endtask

   task automatic wait_gap(output int k);
      k = 0;
      while (!bus.cmd_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
         if (k == 1) chk("done_one_cycle", bus.done, 0);
      end
   endtask

   task automatic cmp_bits(input string name);
      int bad;
      bad = -1;
      chk({name, "_nbits"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         if (got_q[i] != exp_q[i] && bad < 0) bad = i;
      end
      chk({name, "_first_bad_bit"}, bad, -1);
   endtask

   // Complete frame after accept: served bits, end-of-frame pulse, gap length.
   task automatic finish_frame(input string name, input bit pre);
      bit ended;
      int k;
      rdy_bad = 0;
      pre_bad = 0;
      serve(100000, ended);
      chk({name, "_ended"}, ended, 1);
      chk({name, "_done"}, bus.done, 1);
      chk({name, "_busy_off"}, bus.busy, 0);
      chk({name, "_pre_held"}, pre_bad, 0);
      chk({name, "_ready_low"}, rdy_bad, 0);
      chk({name, "_pre_value"}, bus.enc_preamble, pre);
      cmp_bits(name);
      wait_gap(k);
      chk({name, "_gap"}, k, MIN_GAP);
   endtask

   task automatic run_frame(input string name, input logic [MAX_BITS-1:0] d, input int len,
                            input bit pre, input bit crc);
      build_exp(d, len, crc);
      chk({name, "_idle_rst"}, bus.enc_rst, 1);
      send_cmd(d, len, pre, crc);
      chk({name, "_rst_fall"}, bus.enc_rst, 0);
      chk({name, "_busy_on"}, bus.busy, 1);
      chk({name, "_pre_accept"}, bus.enc_preamble, pre);
      finish_frame(name, pre);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[6];
      logic [MAX_BITS-1:0] rd;
      logic [MAX_BITS-1:0] rd2;
      bit ended;
      int k;
      int len;

      vt[0] = '{data: 128'h20_1234, len: 22, pre: 1'b1, crc: 1'b0, nbits: 22};
      vt[1] = '{data: 128'hA5, len: 8, pre: 1'b0, crc: 1'b0, nbits: 8};
      vt[2] = '{data: 128'h1, len: 1, pre: 1'b1, crc: 1'b0, nbits: 1};
      vt[3] = '{data: {$urandom(), $urandom(), $urandom(), $urandom()}, len: 128, pre: 1'b0,
                crc: 1'b0, nbits: 128};
      vt[4] = '{data: {$urandom(), $urandom(), $urandom(), $urandom()}, len: 200, pre: 1'b1,
                crc: 1'b0, nbits: 128};
      vt[5] = '{data: 128'h3_C0F3, len: 18, pre: 1'b0, crc: 1'b1, nbits: CRC_ON ? 34 : 18};

      bus.cmd_data     = '0;
      bus.cmd_len      = '0;
      bus.cmd_preamble = 1'b0;
      bus.cmd_crc16    = 1'b0;
      bus.cmd_valid    = 1'b0;
      bus.enc_bit_req  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_enc_rst", bus.enc_rst, 1);
      chk("reset_enc_bit", bus.enc_bit, 0);
      chk("reset_enc_pre", bus.enc_preamble, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_ready", bus.cmd_ready, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         run_frame($sformatf("vec%0d", i), vt[i].data, vt[i].len, vt[i].pre, vt[i].crc);
         chk($sformatf("vec%0d_table_nbits", i), got_q.size(), vt[i].nbits);
      end

`ifdef CMD_CRC_EN
      run_frame("crc_check", 128'h31_3233_3435_3637_3839, 72, 1'b1, 1'b1);
      run_frame("crc_off", 128'h31_3233_3435_3637_3839, 72, 1'b1, 1'b0);
`endif

      // cmd_valid held with new data through busy and gap: taken on first IDLE cycle.
      rd  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rd2 = {$urandom(), $urandom(), $urandom(), $urandom()};
      build_exp(rd, 12, 1'b0);
      send_cmd(rd, 12, 1'b1, 1'b0);
      bus.cmd_data     = rd2;
      bus.cmd_len      = LEN_W'(9);
      bus.cmd_preamble = 1'b0;
      bus.cmd_valid    = 1'b1;
      rdy_bad = 0;
      pre_bad = 0;
      serve(100000, ended);
      chk("hold_first_ended", ended, 1);
      chk("hold_first_ready_low", rdy_bad, 0);
      chk("hold_first_pre", bus.enc_preamble, 1);
      cmp_bits("hold_first");
      wait_gap(k);
      chk("hold_gap", k, MIN_GAP);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      chk("hold_second_accept", bus.enc_rst, 0);
      chk("hold_second_pre", bus.enc_preamble, 0);
      build_exp(rd2, 9, 1'b0);
      finish_frame("hold_second", 1'b0);

      // Zero-length command: dropped with a done pulse, encoder never released.
      send_cmd(128'hFF, 0, 1'b1, 1'b0);
      chk("zero_done", bus.done, 1);
      chk("zero_enc_rst", bus.enc_rst, 1);
      chk("zero_ready", bus.cmd_ready, 1);
      chk("zero_busy", bus.busy, 0);
      @(posedge clk); #1;
      chk("zero_done_clear", bus.done, 0);
      chk("zero_enc_rst_hold", bus.enc_rst, 1);

      // Reset after the 5th request of a 40-bit frame.
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      build_exp(rd, 40, 1'b0);
      send_cmd(rd, 40, 1'b1, 1'b0);
      serve(5, ended);
      chk("abort_not_ended", ended, 0);
      chk("abort_5_bits", got_q.size(), 5);
      chk("abort_prefix", {got_q[0], got_q[1], got_q[2], got_q[3], got_q[4]},
          {exp_q[0], exp_q[1], exp_q[2], exp_q[3], exp_q[4]});
      rst = 1'b1;
      #1;
      chk("abort_enc_rst", bus.enc_rst, 1);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_pre", bus.enc_preamble, 0);
      chk("abort_ready", bus.cmd_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_no_done", bus.done, 0);
      run_frame("after_abort", {$urandom(), $urandom(), $urandom(), $urandom()}, 10, 1'b0, 1'b0);

      // Random frames against the reference model.
      for (int i = 0; i < 25; i++) begin
         rd  = {$urandom(), $urandom(), $urandom(), $urandom()};
         len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(129, 255))
                                           : int'($urandom_range(1, 48));
         run_frame($sformatf("rnd%0d", i), rd, len, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
